gate_sweep_sequencer: RTL

GATE_SWEEP_SEQUENCER -- requirements
Module: gate_sweep_sequencer

---
 rtl/gate_test_pkg.sv | 20 ++
 rtl/gate_golden.sv | 14 +
 rtl/gate_sweep_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/gate_test_pkg.sv
// rtl/gate_test_pkg.sv - shared state encoding and vector-order constants for the gate sweep
package gate_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [1:0] VEC_FIRST   = 2'b00;
  localparam logic [1:0] VEC_LAST    = 2'b11;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Vectors are visited as {a,b} = 00, 01, 10, 11, i.e. a plain binary increment.
  function automatic logic [1:0] vec_next(input logic [1:0] i_vec);
    return i_vec + 2'd1;
  endfunction

endpackage

// File: rtl/gate_golden.sv
// rtl/gate_golden.sv - combinational reference outputs NOT(a), NAND(a,b), NOR(a,b)
module gate_golden (
  input  logic i_a,
  input  logic i_b,
  output logic o_exp_y0,
  output logic o_exp_y1,
  output logic o_exp_y2
);

  assign o_exp_y0 = ~i_a;
  assign o_exp_y1 = ~(i_a & i_b);
  assign o_exp_y2 = ~(i_a | i_b);

endmodule

// File: rtl/gate_sweep_sequencer.sv
// rtl/gate_sweep_sequencer.sv - sweeps all {a,b} vectors through a gate unit and scores its outputs
module gate_sweep_sequencer
  import gate_test_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y0,
  input  logic       gate_y1,
  input  logic       gate_y2,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt,
  output logic [2:0] err_vec,
  output logic [1:0] fail_idx
);

  localparam logic [3:0] SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOOP_LAST     = 8'(LOOPS - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_idx;
  logic [7:0] r_loop;
  logic [3:0] r_settle;
  logic       r_gate_a;
  logic       r_gate_b;
  logic [7:0] r_err_cnt;
  logic [2:0] r_err_vec;
  logic [1:0] r_fail_idx;
  logic       r_pass;

  logic       w_exp_y0;
  logic       w_exp_y1;
  logic       w_exp_y2;
  logic [2:0] w_mismatch;
  logic       w_last_vec;
  logic       w_last_loop;

  gate_golden u_golden (
    .i_a      (r_gate_a),
    .i_b      (r_gate_b),
    .o_exp_y0 (w_exp_y0),
    .o_exp_y1 (w_exp_y1),
    .o_exp_y2 (w_exp_y2)
  );

  assign w_mismatch  = {gate_y2 ^ w_exp_y2, gate_y1 ^ w_exp_y1, gate_y0 ^ w_exp_y0};
  assign w_last_vec  = (r_idx == VEC_LAST);
  assign w_last_loop = (r_loop >= LOOP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_next_state = ST_SETTLE;
      ST_SETTLE: if (r_settle == 4'd0) w_next_state = ST_CHECK;
      ST_CHECK:  w_next_state = (w_last_vec && w_last_loop) ? ST_FINISH : ST_SETTLE;
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= 2'd0;
      r_loop     <= 8'd0;
      r_settle   <= 4'd0;
      r_gate_a   <= 1'b0;
      r_gate_b   <= 1'b0;
      r_err_cnt  <= 8'd0;
      r_err_vec  <= 3'd0;
      r_fail_idx <= 2'd0;
      r_pass     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx                <= VEC_FIRST;
            r_loop               <= 8'd0;
            r_settle             <= SETTLE_RELOAD;
            {r_gate_a, r_gate_b} <= VEC_FIRST;
            r_err_cnt            <= 8'd0;
            r_err_vec            <= 3'd0;
            r_fail_idx           <= 2'd0;
            r_pass               <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
        end
        ST_CHECK: begin
          // A zero count marks the first failure of the run; saturation never wraps back to zero.
          if (|w_mismatch) begin
            if (r_err_cnt != ERR_CNT_MAX) r_err_cnt <= r_err_cnt + 8'd1;
            r_err_vec <= r_err_vec | w_mismatch;
            if (r_err_cnt == 8'd0) r_fail_idx <= r_idx;
          end
          r_settle <= SETTLE_RELOAD;
          if (!w_last_vec) begin
            r_idx                <= vec_next(r_idx);
            {r_gate_a, r_gate_b} <= vec_next(r_idx);
          end else if (!w_last_loop) begin
            r_idx                <= VEC_FIRST;
            r_loop               <= r_loop + 8'd1;
            {r_gate_a, r_gate_b} <= VEC_FIRST;
          end else begin
            {r_gate_a, r_gate_b} <= 2'b00;
          end
        end
        ST_FINISH: begin
          r_pass <= (r_err_cnt == 8'd0);
        end
        default: begin
        end
      endcase
    end
  end

  assign gate_a   = r_gate_a;
  assign gate_b   = r_gate_b;
  assign busy     = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
  assign done     = (r_state == ST_FINISH);
  assign pass     = r_pass;
  assign err_cnt  = r_err_cnt;
  assign err_vec  = r_err_vec;
  assign fail_idx = r_fail_idx;

endmodule
